pr_decouple_ctrl: RTL and testbench
===================================

Name: pr_decouple_ctrl

Overview:
- Sequencer for one reconfigurable-module (RM) partition during partial reconfiguration through the ICAP controller.
- Drives the enable of the partition's decoupling stage and the RM's active-low reset. Launches the ICAP transfer and waits for it to finish.
- After reconfiguration it resets the new RM, recouples the partition and reports completion or error to the host-side logic.

Parameters:
- DRAIN_CYCLES, 16: cycles to wait after a request before decoupling, so in-flight RM outputs can settle; must be >= 1.
- RST_CYCLES, 8: cycles the RM reset is held low while the partition is still decoupled; must be >= 1.
- SETTLE_CYCLES, 4: cycles after recoupling before done is signalled; must be >= 1.
- TIMEOUT_CYCLES, 1000000: maximum cycles allowed in RECONFIG before an error is flagged.
- CNT_W, 32: width of the shared down-counter; must hold every *_CYCLES value.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pr_req  in  1  level request to start a reconfiguration; sampled only in IDLE.
- err_clr  in  1  single-cycle pulse that clears a sticky error; honoured only in ERROR.
- icap_done  in  1  single-cycle pulse from the ICAP controller: bitstream fully written.
- icap_err  in  1  single-cycle pulse from the ICAP controller: write failed.
- icap_start  out  1  single-cycle pulse that starts the ICAP bitstream transfer.
- couple_en  out  1  enable to the decoupling stage; 1 = RM outputs, clock and reset pass through.
- rm_rstn  out  1  active-low reset to the RM.
- pr_busy  out  1  high in every state except IDLE and ERROR.
- pr_done  out  1  single-cycle pulse when a sequence completes successfully.
- pr_error  out  1  sticky error; high exactly while in ERROR.
- state  out  3  current state encoding, for debug.

Behaviour:
- One Moore FSM plus one CNT_W down-counter (cnt). All outputs are registered.
- State encodings: IDLE=0, DRAIN=1, START=2, RECONFIG=3, RESET_RM=4, RECOUPLE=5, DONE=6, ERROR=7.
- On asynchronous reset:
  - state=RESET_RM, cnt=RST_CYCLES-1.
  - couple_en=0, rm_rstn=0, icap_start=0, pr_done=0, pr_error=0, pr_busy=1.
  - Result: the boot path resets the RM and then recouples, exactly like the tail of a reconfiguration.
- IDLE: couple_en=1, rm_rstn=1. If pr_req=1, load cnt=DRAIN_CYCLES-1 and go to DRAIN.
- DRAIN: couple_en is still 1. Decrement cnt. When cnt==0, drop couple_en to 0 and go to START.
- START: one cycle. icap_start=1 in this cycle only. Load cnt=TIMEOUT_CYCLES-1 and go to RECONFIG.
- RECONFIG: couple_en=0, rm_rstn=0. Resolve events in this priority order:
  1. icap_err=1 -> ERROR.
  2. Otherwise icap_done=1 -> load cnt=RST_CYCLES-1, go to RESET_RM.
  3. Otherwise cnt==0 -> ERROR (timeout).
  4. Otherwise decrement cnt.
  - Simultaneous icap_err and icap_done: icap_err wins.
- RESET_RM: couple_en=0, rm_rstn=0. Decrement cnt. When cnt==0, set couple_en=1, load cnt=SETTLE_CYCLES-1 and go to RECOUPLE.
- RECOUPLE: couple_en=1, rm_rstn still 0 (RM sees a clocked reset). Decrement cnt. When cnt==0, set rm_rstn=1 and go to DONE.
- DONE: one cycle. pr_done=1, then go to IDLE.
- ERROR:
  - couple_en=0, rm_rstn=0, pr_error=1. The partition stays isolated.
  - err_clr=1 -> load cnt=RST_CYCLES-1 and go to RESET_RM (recovery path). pr_error goes low in the cycle that RESET_RM is entered.
- pr_req handling:
  - Ignored outside IDLE; no queuing.
  - If pr_req is still high on return to IDLE, a new sequence starts after one IDLE cycle.
- icap_done or icap_err outside RECONFIG: ignored.
- err_clr outside ERROR: ignored.
- Latency, request to icap_start: pr_req is sampled in IDLE at cycle 0; DRAIN is occupied for DRAIN_CYCLES cycles; icap_start is high in cycle DRAIN_CYCLES+1.
- Latency, icap_done to pr_done: RST_CYCLES+SETTLE_CYCLES+1 cycles.
- Reset asserted mid-sequence: immediate asynchronous return to the reset state above. No icap_start is issued and no pr_done pulse occurs.
- Invariant: couple_en=1 never coincides with state START, RECONFIG or ERROR.

Test Plan:
- Reset release (defaults 16/8/4):
  - Required: rm_rstn=0 and couple_en=0 for 8 cycles; then couple_en=1 with rm_rstn=0 for 4 cycles; then a 1-cycle pr_done and state=0.
- Nominal sequence: pulse pr_req in IDLE.
  - Required: couple_en drops 16 cycles later; icap_start is high for exactly one cycle in the following cycle.
  - Then drive icap_done 50 cycles later. Required: pr_done is high exactly 13 cycles after icap_done; couple_en=1 and rm_rstn=1 afterwards.
- Timeout: set TIMEOUT_CYCLES=20 and never drive icap_done.
  - Required: ERROR is entered 20 cycles after icap_start; pr_error=1, couple_en=0, pr_busy=0.
  - Pulse err_clr. Required: the RESET_RM/RECOUPLE path runs, then pr_done fires.
- icap_err and icap_done in the same RECONFIG cycle -> state=7 and no pr_done.
  - Also pulse icap_done while in IDLE -> no state change.
- Assert rst for 1 cycle during RECONFIG.
  - Required: state=4, couple_en=0, rm_rstn=0 immediately, without waiting for a clock edge. No second icap_start.
- Hold pr_req high continuously.
  - Required: back-to-back sequences, each separated by exactly one IDLE cycle (state=0 for 1 cycle).

Source files
------------

// File: rtl/pr_decouple_ctrl.sv
// Partial-reconfiguration sequencer for one RM partition: drains, decouples, launches the ICAP
// transfer, resets the new RM, recouples and reports done or a sticky error.
module pr_decouple_ctrl #(
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned RST_CYCLES     = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pr_req,
  input  logic       err_clr,
  input  logic       icap_done,
  input  logic       icap_err,
  output logic       icap_start,
  output logic       couple_en,
  output logic       rm_rstn,
  output logic       pr_busy,
  output logic       pr_done,
  output logic       pr_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StDrain    = 3'd1,
    StStart    = 3'd2,
    StReconfig = 3'd3,
    StResetRm  = 3'd4,
    StRecouple = 3'd5,
    StDone     = 3'd6,
    StError    = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] DrainLoad   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RstLoad     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLoad  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLoad = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;
  logic             icap_start_d, couple_en_d, rm_rstn_d, pr_busy_d, pr_done_d, pr_error_d;

  assign cnt_zero = (cnt_q == '0);
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pr_req) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end
      end
      StDrain: begin
        if (cnt_zero) state_d = StStart;
        else          cnt_d   = cnt_q - CntOne;
      end
      StStart: begin
        state_d = StReconfig;
        cnt_d   = TimeoutLoad;
      end
      StReconfig: begin
        // A write failure outranks a simultaneous completion.
        if (icap_err) begin
          state_d = StError;
        end else if (icap_done) begin
          state_d = StResetRm;
          cnt_d   = RstLoad;
        end else if (cnt_zero) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StResetRm: begin
        if (cnt_zero) begin
          state_d = StRecouple;
          cnt_d   = SettleLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StRecouple: begin
        if (cnt_zero) state_d = StDone;
        else          cnt_d   = cnt_q - CntOne;
      end
      StDone: state_d = StIdle;
      StError: begin
        if (err_clr) begin
          state_d = StResetRm;
          cnt_d   = RstLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with state.
    couple_en_d  = (state_d == StIdle) || (state_d == StDrain) ||
                   (state_d == StRecouple) || (state_d == StDone);
    rm_rstn_d    = (state_d == StIdle) || (state_d == StDrain) ||
                   (state_d == StStart) || (state_d == StDone);
    icap_start_d = (state_d == StStart);
    pr_done_d    = (state_d == StDone);
    pr_error_d   = (state_d == StError);
    pr_busy_d    = (state_d != StIdle) && (state_d != StError);
  end

  // Reset lands in RESET_RM so the boot path reuses the tail of a reconfiguration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StResetRm;
      cnt_q      <= RstLoad;
      icap_start <= 1'b0;
      couple_en  <= 1'b0;
      rm_rstn    <= 1'b0;
      pr_busy    <= 1'b1;
      pr_done    <= 1'b0;
      pr_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      icap_start <= icap_start_d;
      couple_en  <= couple_en_d;
      rm_rstn    <= rm_rstn_d;
      pr_busy    <= pr_busy_d;
      pr_done    <= pr_done_d;
      pr_error   <= pr_error_d;
    end
  end

endmodule

// File: tb/tb_pr_decouple_ctrl.sv
// Directed bench for pr_decouple_ctrl: one default instance plus one with a short ICAP timeout.
module tb_pr_decouple_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pr_req, err_clr, icap_done, icap_err;
  logic       icap_start, couple_en, rm_rstn, pr_busy, pr_done, pr_error;
  logic [2:0] state;

  logic       rst_b, pr_req_b, err_clr_b, icap_done_b, icap_err_b;
  logic       icap_start_b, couple_en_b, rm_rstn_b, pr_busy_b, pr_done_b, pr_error_b;
  logic [2:0] state_b;

  int n_checks = 0;
  int n_pass   = 0;

  pr_decouple_ctrl dut (
    .clk(clk), .rst(rst), .pr_req(pr_req), .err_clr(err_clr), .icap_done(icap_done),
    .icap_err(icap_err), .icap_start(icap_start), .couple_en(couple_en), .rm_rstn(rm_rstn),
    .pr_busy(pr_busy), .pr_done(pr_done), .pr_error(pr_error), .state(state)
  );

  pr_decouple_ctrl #(.TIMEOUT_CYCLES(20)) dut_to (
    .clk(clk), .rst(rst_b), .pr_req(pr_req_b), .err_clr(err_clr_b), .icap_done(icap_done_b),
    .icap_err(icap_err_b), .icap_start(icap_start_b), .couple_en(couple_en_b),
    .rm_rstn(rm_rstn_b), .pr_busy(pr_busy_b), .pr_done(pr_done_b), .pr_error(pr_error_b),
    .state(state_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_b = 1'b1;
    pr_req = 0; err_clr = 0; icap_done = 0; icap_err = 0;
    pr_req_b = 0; err_clr_b = 0; icap_done_b = 0; icap_err_b = 0;
    steps(3);
    n_checks++;
    if ({state, couple_en, rm_rstn, pr_busy, pr_done, pr_error, icap_start} !== 9'b100_0010_00)
      $display("FAIL reset_values got %b want %b",
               {state, couple_en, rm_rstn, pr_busy, pr_done, pr_error, icap_start}, 9'b100001000);
    else n_pass++;
    rst = 1'b0; rst_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({state, couple_en, rm_rstn} !== 5'b100_00)
        $display("FAIL boot_reset_rm cyc %0d got %b want %b", i, {state, couple_en, rm_rstn},
                 5'b10000);
      else n_pass++;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({state, couple_en, rm_rstn} !== 5'b101_10)
        $display("FAIL boot_recouple cyc %0d got %b want %b", i, {state, couple_en, rm_rstn},
                 5'b10110);
      else n_pass++;
      step();
    end
    n_checks++;
    if ({state, pr_done} !== 4'b110_1)
      $display("FAIL boot_done got %b want %b", {state, pr_done}, 4'b1101);
    else n_pass++;
    step();
    n_checks++;
    if ({state, pr_done, couple_en, rm_rstn, pr_busy} !== 7'b000_0110)
      $display("FAIL boot_idle got %b want %b", {state, pr_done, couple_en, rm_rstn, pr_busy},
               7'b0000110);
    else n_pass++;
  endtask

  task automatic test_nominal();
    int early_done;
    int extra_start;
    pr_req = 1'b1;
    step();
    pr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({state, couple_en, icap_start} !== 5'b001_10)
        $display("FAIL drain cyc %0d got %b want %b", i, {state, couple_en, icap_start}, 5'b00110);
      else n_pass++;
      step();
    end
    n_checks++;
    if ({state, couple_en, icap_start} !== 5'b010_01)
      $display("FAIL start got %b want %b", {state, couple_en, icap_start}, 5'b01001);
    else n_pass++;
    step();
    n_checks++;
    if ({state, couple_en, rm_rstn, icap_start} !== 6'b011_000)
      $display("FAIL reconfig_entry got %b want %b", {state, couple_en, rm_rstn, icap_start},
               6'b011000);
    else n_pass++;
    extra_start = 0;
    for (int i = 0; i < 49; i++) begin
      step();
      if (icap_start) extra_start++;
    end
    n_checks++;
    if (extra_start !== 0) $display("FAIL single_start got %0d extra want 0", extra_start);
    else n_pass++;
    icap_done = 1'b1;
    step();
    icap_done = 1'b0;
    early_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (pr_done) early_done++;
      step();
    end
    n_checks++;
    if (early_done !== 0) $display("FAIL done_early got %0d want 0", early_done);
    else n_pass++;
    n_checks++;
    if ({state, pr_done} !== 4'b110_1)
      $display("FAIL done_latency got %b want %b", {state, pr_done}, 4'b1101);
    else n_pass++;
    step();
    n_checks++;
    if ({state, couple_en, rm_rstn, pr_done} !== 6'b000_110)
      $display("FAIL post_done got %b want %b", {state, couple_en, rm_rstn, pr_done}, 6'b000110);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n_reconf;
    pr_req_b = 1'b1;
    step();
    pr_req_b = 1'b0;
    steps(16);
    n_checks++;
    if ({state_b, icap_start_b} !== 4'b010_1)
      $display("FAIL to_start got %b want %b", {state_b, icap_start_b}, 4'b0101);
    else n_pass++;
    n_reconf = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (state_b == 3'd3) n_reconf++;
      else break;
    end
    n_checks++;
    if (n_reconf !== 20) $display("FAIL to_reconfig_cycles got %0d want 20", n_reconf);
    else n_pass++;
    n_checks++;
    if ({state_b, pr_error_b, couple_en_b, pr_busy_b, rm_rstn_b} !== 7'b111_1000)
      $display("FAIL to_error got %b want %b",
               {state_b, pr_error_b, couple_en_b, pr_busy_b, rm_rstn_b}, 7'b1111000);
    else n_pass++;
    steps(5);
    n_checks++;
    if ({state_b, pr_error_b} !== 4'b111_1)
      $display("FAIL to_sticky got %b want %b", {state_b, pr_error_b}, 4'b1111);
    else n_pass++;
    err_clr_b = 1'b1;
    step();
    err_clr_b = 1'b0;
    n_checks++;
    if ({state_b, pr_error_b, couple_en_b, rm_rstn_b} !== 6'b100_000)
      $display("FAIL to_clr got %b want %b", {state_b, pr_error_b, couple_en_b, rm_rstn_b},
               6'b100000);
    else n_pass++;
    steps(8);
    n_checks++;
    if ({state_b, couple_en_b, rm_rstn_b} !== 5'b101_10)
      $display("FAIL to_recouple got %b want %b", {state_b, couple_en_b, rm_rstn_b}, 5'b10110);
    else n_pass++;
    steps(4);
    n_checks++;
    if ({state_b, pr_done_b} !== 4'b110_1)
      $display("FAIL to_recover_done got %b want %b", {state_b, pr_done_b}, 4'b1101);
    else n_pass++;
    step();
  endtask

  task automatic test_err_priority();
    int seen_done;
    pr_req = 1'b1;
    step();
    pr_req = 1'b0;
    steps(17);
    n_checks++;
    if (state !== 3'd3) $display("FAIL prio_reach_reconfig got %0d want 3", state);
    else n_pass++;
    icap_err = 1'b1; icap_done = 1'b1;
    step();
    icap_err = 1'b0; icap_done = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (pr_done || state !== 3'd7) seen_done++;
      step();
    end
    n_checks++;
    if ({state, pr_error, seen_done[3:0]} !== 8'b111_1_0000)
      $display("FAIL err_wins got %b want %b", {state, pr_error, seen_done[3:0]}, 8'b11110000);
    else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    steps(13);
    n_checks++;
    if (state !== 3'd0) $display("FAIL prio_back_idle got %0d want 0", state);
    else n_pass++;
    icap_done = 1'b1; err_clr = 1'b1;
    step();
    icap_done = 1'b0; err_clr = 1'b0;
    step();
    n_checks++;
    if ({state, pr_done, pr_error} !== 5'b000_00)
      $display("FAIL idle_ignore got %b want %b", {state, pr_done, pr_error}, 5'b00000);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n_start;
    pr_req = 1'b1;
    step();
    pr_req = 1'b0;
    steps(17);
    n_checks++;
    if (state !== 3'd3) $display("FAIL mid_reach_reconfig got %0d want 3", state);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({state, couple_en, rm_rstn} !== 5'b100_00)
      $display("FAIL async_reset got %b want %b", {state, couple_en, rm_rstn}, 5'b10000);
    else n_pass++;
    step();
    rst = 1'b0;
    n_start = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (icap_start) n_start++;
    end
    n_checks++;
    if ({n_start[3:0], state} !== 7'b0000_000)
      $display("FAIL mid_no_restart got starts=%0d state=%0d want 0 0", n_start, state);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k;
    pr_req = 1'b1;
    for (int s = 0; s < 2; s++) begin
      k = 0;
      while (state !== 3'd3 && k < 40) begin step(); k++; end
      n_checks++;
      if (state !== 3'd3) $display("FAIL b2b_reconfig seq %0d got %0d want 3", s, state);
      else n_pass++;
      icap_done = 1'b1;
      step();
      icap_done = 1'b0;
      k = 0;
      while (state !== 3'd6 && k < 40) begin step(); k++; end
      step();
      n_checks++;
      if (state !== 3'd0) $display("FAIL b2b_idle seq %0d got %0d want 0", s, state);
      else n_pass++;
      step();
      n_checks++;
      if (state !== 3'd1) $display("FAIL b2b_restart seq %0d got %0d want 1", s, state);
      else n_pass++;
    end
    pr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_err_priority();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
